// File: rtl/rom_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// rom_ctrl_pkg
// Shared definitions for the ROM frame reader: controller state encoding and
// the read latency of the picture ROM (data valid this many cycles after the
// read strobe).
// -----------------------------------------------------------------------------
package rom_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam int ROM_LATENCY = 1;

endpackage

// File: rtl/rom_rd_fifo.sv
// -----------------------------------------------------------------------------
// rom_rd_fifo
// Synchronous single-clock FIFO buffering ROM read data ahead of the pixel
// output handshake. The head entry is presented combinationally on o_rd_data.
//
// Ports:
//   clk, rst    clock, synchronous active-high reset (pointers and count)
//   i_wr_en     push i_wr_data (ignored when full)
//   i_wr_data   data to push
//   i_rd_en     pop the head entry (ignored when empty)
//   o_rd_data   current head entry
//   o_full      DEPTH entries held
//   o_empty     no entries held
//   o_count     number of entries held, 0..DEPTH
// -----------------------------------------------------------------------------
module rom_rd_fifo #(
  parameter int DATA_WIDTH = 24,
  parameter int DEPTH      = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_wr_en,
  input  logic [DATA_WIDTH-1:0]    i_wr_data,
  input  logic                     i_rd_en,
  output logic [DATA_WIDTH-1:0]    o_rd_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  logic                  w_push;
  logic                  w_pop;

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_rd_data = r_mem[r_rd_ptr];

  assign w_push = i_wr_en && !o_full;
  assign w_pop  = i_rd_en && !o_empty;

  // Pointer wrap relies on DEPTH being a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wr_data;
  end

endmodule

// File: rtl/rom_frame_reader.sv
// -----------------------------------------------------------------------------
// rom_frame_reader
// Fetches one IMG_W x IMG_H frame from a picture ROM in raster order on each
// accepted frame_start and streams it out over a valid/ready pixel interface
// with start-of-frame, end-of-line and end-of-frame markers.
//
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   frame_start    one-cycle request for a full frame fetch
//   rom_addr       ROM read address (holds last issued address when idle)
//   rom_rd_en      ROM read strobe, one read per high cycle
//   rom_rd_data    ROM data, valid ROM_LATENCY cycles after rom_rd_en
//   m_valid/m_ready  output pixel handshake
//   m_data         output pixel
//   m_sof/m_eol/m_eof  frame/line markers, qualified by m_valid
//   busy           frame in progress
//   frame_done     one-cycle pulse after the last pixel is transferred
//   start_err      sticky: frame_start seen while busy
// -----------------------------------------------------------------------------
module rom_frame_reader
  import rom_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 24,
  parameter int IMG_W      = 256,
  parameter int IMG_H      = 256,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  frame_start,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  output logic                  rom_rd_en,
  input  logic [DATA_WIDTH-1:0] rom_rd_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_sof,
  output logic                  m_eol,
  output logic                  m_eof,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  start_err
);

  localparam int NPIX = IMG_W * IMG_H;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NPIX - 1);
  localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [ADDR_WIDTH-1:0]   w_issue_addr;
  logic                    w_rd_en;
  logic [ROM_LATENCY-1:0]  r_rd_vld_p1;
  logic [CW-1:0]           w_inflight;
  logic [CW:0]             w_occ;
  logic                    w_credit;
  logic                    w_fifo_full;
  logic                    w_fifo_empty;
  logic [CW-1:0]           w_fifo_count;
  logic [DATA_WIDTH-1:0]   w_fifo_head;
  logic [XW-1:0]           r_x;
  logic [YW-1:0]           r_y;
  logic                    r_done;
  logic                    r_err;
  logic                    w_xfer;
  logic                    w_at_eol;
  logic                    w_at_eof;

  rom_rd_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (r_rd_vld_p1[ROM_LATENCY-1]),
    .i_wr_data (rom_rd_data),
    .i_rd_en   (w_xfer),
    .o_rd_data (w_fifo_head),
    .o_full    (w_fifo_full),
    .o_empty   (w_fifo_empty),
    .o_count   (w_fifo_count)
  );

  // Reads still travelling through the ROM count against FIFO space, so the
  // FIFO can never be asked to accept more than it holds.
  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < ROM_LATENCY; i++) begin
      w_inflight = w_inflight + CW'(r_rd_vld_p1[i]);
    end
  end

  assign w_occ    = {1'b0, w_fifo_count} + {1'b0, w_inflight};
  assign w_credit = !w_fifo_full && (w_occ < (CW + 1)'(FIFO_DEPTH));

  assign w_xfer   = m_valid && m_ready;
  assign w_at_eol = (r_x == XW'(IMG_W - 1));
  assign w_at_eof = w_at_eol && (r_y == YW'(IMG_H - 1));

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // The first read is issued in the frame_start cycle itself so the first
  // pixel reaches the FIFO head two cycles after the request.
  always_comb begin
    w_state_nxt  = r_state;
    w_rd_en      = 1'b0;
    w_issue_addr = r_addr + ADDR_WIDTH'(1);
    case (r_state)
      ST_IDLE: begin
        if (frame_start) begin
          w_rd_en      = 1'b1;
          w_issue_addr = '0;
          w_state_nxt  = (NPIX == 1) ? ST_DRAIN : ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (w_credit) begin
          w_rd_en = 1'b1;
          if (w_issue_addr == LAST_ADDR) w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (w_xfer && w_at_eof) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (rst) w_rd_en = 1'b0;
  end

  // Read issue / ROM return stage
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr      <= '0;
      r_rd_vld_p1 <= '0;
    end else begin
      r_rd_vld_p1 <= (r_rd_vld_p1 << 1) | ROM_LATENCY'(w_rd_en);
      if (w_rd_en) r_addr <= w_issue_addr;
    end
  end

  // Output transfer stage: raster position, completion and error tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      r_x    <= '0;
      r_y    <= '0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_done <= w_xfer && w_at_eof;
      if (frame_start && busy) r_err <= 1'b1;
      if (w_xfer) begin
        if (w_at_eol) begin
          r_x <= '0;
          r_y <= w_at_eof ? '0 : r_y + YW'(1);
        end else begin
          r_x <= r_x + XW'(1);
        end
      end
    end
  end

  assign rom_rd_en  = w_rd_en;
  assign rom_addr   = w_rd_en ? w_issue_addr : r_addr;
  assign m_valid    = !w_fifo_empty;
  assign m_data     = w_fifo_empty ? '0 : w_fifo_head;
  assign m_sof      = m_valid && (r_x == '0) && (r_y == '0);
  assign m_eol      = m_valid && w_at_eol;
  assign m_eof      = m_valid && w_at_eof;
  assign busy       = (r_state != ST_IDLE);
  assign frame_done = r_done;
  assign start_err  = r_err;

endmodule

// File: tb/tb_rom_frame_reader.sv
// -----------------------------------------------------------------------------
// tb_rom_frame_reader
// Self-checking bench for rom_frame_reader with a 4x2 frame and a ROM whose
// word equals its address. A frame-level reference model tracks reads issued,
// data returned and pixels transferred, and predicts every output each cycle.
// -----------------------------------------------------------------------------
module tb_rom_frame_reader;

  localparam int AW = 8;
  localparam int DW = 24;
  localparam int W  = 4;
  localparam int H  = 2;
  localparam int N  = W * H;
  localparam int D  = 4;

  logic          clk         = 1'b0;
  logic          rst         = 1'b1;
  logic          frame_start = 1'b0;
  logic          m_ready     = 1'b0;
  logic [AW-1:0] rom_addr;
  logic          rom_rd_en;
  logic [DW-1:0] rom_rd_data = '0;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_sof, m_eol, m_eof;
  logic          busy, frame_done, start_err;

  rom_frame_reader #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .IMG_W      (W),
    .IMG_H      (H),
    .FIFO_DEPTH (D)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .frame_start (frame_start),
    .rom_addr    (rom_addr),
    .rom_rd_en   (rom_rd_en),
    .rom_rd_data (rom_rd_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .m_sof       (m_sof),
    .m_eol       (m_eol),
    .m_eof       (m_eof),
    .busy        (busy),
    .frame_done  (frame_done),
    .start_err   (start_err)
  );

  always #5 clk = ~clk;

  // ROM: word equals address, data returned one cycle after the strobe.
  always @(posedge clk) begin
    if (rom_rd_en) rom_rd_data <= DW'(rom_addr);
  end

  int checks = 0;
  int errors = 0;

  // Reference model state (frame-level bookkeeping)
  int n_issued, n_arrived, n_xfer, last_addr, frames;
  int dut_xfers, dut_reads;
  bit mb, merr, mdone;
  bit e_acc, e_rd, e_vld;
  int e_addr;

  typedef struct {
    bit fs;   bit rdy;
    bit e_rd; int e_addr;
    bit e_vld; int e_data;
    bit e_sof; bit e_eol; bit e_eof;
    bit e_busy; bit e_done;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    n_issued  = 0;
    n_arrived = 0;
    n_xfer    = 0;
    last_addr = 0;
    mb        = 1'b0;
    merr      = 1'b0;
    mdone     = 1'b0;
  endtask

  task automatic check_cycle();
    e_acc  = frame_start && !mb && !rst;
    e_rd   = !rst && (e_acc || (mb && n_issued < N && (n_issued - n_xfer) < D));
    e_addr = e_rd ? (e_acc ? 0 : n_issued) : last_addr;
    e_vld  = n_arrived > n_xfer;
    chk("rd_en",    32'(rom_rd_en), 32'(e_rd));
    chk("rom_addr", 32'(rom_addr),  32'(e_addr));
    chk("m_valid",  32'(m_valid),   32'(e_vld));
    if (e_vld) begin
      chk("m_data", 32'(m_data), 32'(n_xfer));
      chk("m_sof",  32'(m_sof),  32'(n_xfer == 0));
      chk("m_eol",  32'(m_eol),  32'((n_xfer % W) == W - 1));
      chk("m_eof",  32'(m_eof),  32'(n_xfer == N - 1));
    end
    chk("busy",       32'(busy),       32'(mb));
    chk("frame_done", 32'(frame_done), 32'(mdone));
    chk("start_err",  32'(start_err),  32'(merr));
    if (m_valid && m_ready) dut_xfers++;
    if (rom_rd_en) dut_reads++;
  endtask

  task automatic advance();
    bit xfer;
    int arr_next;
    xfer = e_vld && m_ready;
    if (rst) begin
      model_reset();
    end else begin
      if (frame_start && mb) merr = 1'b1;
      arr_next = n_issued;
      if (e_acc) begin
        n_issued = 0;
        n_xfer   = 0;
        arr_next = 0;
        mb       = 1'b1;
      end
      if (e_rd) begin
        n_issued++;
        last_addr = e_addr;
      end
      n_arrived = arr_next;
      mdone = 1'b0;
      if (xfer) begin
        n_xfer++;
        if (n_xfer == N) begin
          mb    = 1'b0;
          mdone = 1'b1;
          frames++;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input bit fs, input bit rdy, input bit rs);
    frame_start = fs;
    m_ready     = rdy;
    rst         = rs;
    #1;
    check_cycle();
    advance();
  endtask

  // mode 0: ready always high; 1: ready pattern 1,0,0,1; 2: random ready
  task automatic run_frame(input int mode, input int budget);
    int f0;
    int k;
    bit rdy;
    f0 = frames;
    k  = 0;
    while (frames == f0 && k < budget) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = ((k % 4) == 0) || ((k % 4) == 3);
        default: rdy = ($urandom_range(0, 2) != 0);
      endcase
      cyc(1'b0, rdy, 1'b0);
      k++;
    end
    if (frames == f0) begin
      checks++;
      errors++;
      $display("FAIL frame_timeout: frame not completed within %0d cycles", budget);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_rom_addr"},   32'(rom_addr),   32'd0);
    chk({tag, "_rom_rd_en"},  32'(rom_rd_en),  32'd0);
    chk({tag, "_m_valid"},    32'(m_valid),    32'd0);
    chk({tag, "_m_data"},     32'(m_data),     32'd0);
    chk({tag, "_m_sof"},      32'(m_sof),      32'd0);
    chk({tag, "_m_eol"},      32'(m_eol),      32'd0);
    chk({tag, "_m_eof"},      32'(m_eof),      32'd0);
    chk({tag, "_busy"},       32'(busy),       32'd0);
    chk({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    chk({tag, "_start_err"},  32'(start_err),  32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int k;
    frames = 0;
    model_reset();

    //                 fs    rdy   rd    addr vld   data sof   eol   eof   busy  done
    tbl[0]  = '{1'b1, 1'b1, 1'b1, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 1'b1, 1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 1'b1, 2, 1'b1, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 1'b1, 3, 1'b1, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 1'b1, 4, 1'b1, 2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 1'b1, 5, 1'b1, 3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 1'b1, 6, 1'b1, 4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 1'b1, 7, 1'b1, 5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 7, 1'b1, 6, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 7, 1'b1, 7, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 7, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 7, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");

    // Basic frame, cycle by cycle against the table
    for (int i = 0; i < 12; i++) begin
      frame_start = tbl[i].fs;
      m_ready     = tbl[i].rdy;
      rst         = 1'b0;
      #1;
      chk($sformatf("tbl%0d_rd_en", i), 32'(rom_rd_en), 32'(tbl[i].e_rd));
      chk($sformatf("tbl%0d_addr", i),  32'(rom_addr),  32'(tbl[i].e_addr));
      chk($sformatf("tbl%0d_valid", i), 32'(m_valid),   32'(tbl[i].e_vld));
      if (tbl[i].e_vld) begin
        chk($sformatf("tbl%0d_data", i), 32'(m_data), 32'(tbl[i].e_data));
        chk($sformatf("tbl%0d_sof", i),  32'(m_sof),  32'(tbl[i].e_sof));
        chk($sformatf("tbl%0d_eol", i),  32'(m_eol),  32'(tbl[i].e_eol));
        chk($sformatf("tbl%0d_eof", i),  32'(m_eof),  32'(tbl[i].e_eof));
      end
      chk($sformatf("tbl%0d_busy", i), 32'(busy),       32'(tbl[i].e_busy));
      chk($sformatf("tbl%0d_done", i), 32'(frame_done), 32'(tbl[i].e_done));
      check_cycle();
      advance();
    end

    // Back-to-back: new frame_start coincident with frame_done
    cyc(1'b1, 1'b1, 1'b0);
    k = 0;
    while (!mdone && k < 40) begin
      cyc(1'b0, 1'b1, 1'b0);
      k++;
    end
    if (!mdone) begin
      checks++;
      errors++;
      $display("FAIL b2b_done_timeout: frame_done not reached within %0d cycles", k);
    end
    dut_xfers = 0;
    cyc(1'b1, 1'b1, 1'b0);
    run_frame(0, 60);
    chk("b2b_pixels", 32'(dut_xfers), 32'(N));
    chk("b2b_start_err", 32'(start_err), 32'd0);

    // Ready toggling 1,0,0,1
    dut_xfers = 0;
    cyc(1'b1, 1'b1, 1'b0);
    run_frame(1, 120);
    chk("toggle_pixels", 32'(dut_xfers), 32'(N));

    // Ready held low for 20 cycles: only FIFO_DEPTH reads may go out
    dut_xfers = 0;
    dut_reads = 0;
    cyc(1'b1, 1'b0, 1'b0);
    repeat (20) cyc(1'b0, 1'b0, 1'b0);
    chk("stall_reads", 32'(dut_reads), 32'(D));
    run_frame(0, 60);
    chk("stall_pixels", 32'(dut_xfers), 32'(N));

    // frame_start while pixel 3 is presented
    dut_xfers = 0;
    cyc(1'b1, 1'b1, 1'b0);
    k = 0;
    while (!(n_xfer == 3 && n_arrived > 3) && k < 20) begin
      cyc(1'b0, 1'b1, 1'b0);
      k++;
    end
    cyc(1'b1, 1'b1, 1'b0);
    run_frame(0, 60);
    chk("busy_start_err", 32'(start_err), 32'd1);
    chk("busy_start_pixels", 32'(dut_xfers), 32'(N));

    // Reset while pixel 5 is pending, then a clean frame
    cyc(1'b1, 1'b1, 1'b0);
    k = 0;
    while (!(n_xfer == 5 && n_arrived > 5) && k < 20) begin
      cyc(1'b0, 1'b1, 1'b0);
      k++;
    end
    cyc(1'b0, 1'b0, 1'b1);
    check_zero("midrst");
    cyc(1'b0, 1'b1, 1'b0);
    dut_xfers = 0;
    cyc(1'b1, 1'b1, 1'b0);
    run_frame(0, 60);
    chk("post_rst_pixels", 32'(dut_xfers), 32'(N));

    // Randomized traffic against the model
    repeat (800) cyc(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0), 1'b0);
    k = 0;
    while (mb && k < 100) begin
      cyc(1'b0, 1'b1, 1'b0);
      k++;
    end
    cyc(1'b0, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rom_frame_reader.md
ROM_FRAME_READER -- requirements
Module: rom_frame_reader

Interface
REQ-001 Parameter ADDR_WIDTH, default 16: picture ROM address width.
REQ-002 Parameter DATA_WIDTH, default 24: pixel width (RGB888).
REQ-003 Parameter IMG_W, default 256: pixels per line.
REQ-004 Parameter IMG_H, default 256: lines per frame; IMG_W*IMG_H SHALL NOT exceed 2**ADDR_WIDTH.
REQ-005 Parameter FIFO_DEPTH, default 4: output buffer entries, power of two, at least 2.
REQ-006 clk  in  1  single clock for the block and the ROM.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 frame_start  in  1  single-cycle pulse that requests one full frame fetch.
REQ-009 rom_addr  out  ADDR_WIDTH  ROM read address.
REQ-010 rom_rd_en  out  1  ROM read strobe, one read per asserted cycle.
REQ-011 rom_rd_data  in  DATA_WIDTH  ROM data, valid exactly 1 cycle after rom_rd_en (unregistered ROM output).
REQ-012 m_valid / m_ready  out / in  1 / 1  output pixel handshake; a transfer occurs when both are high.
REQ-013 m_data  out  DATA_WIDTH  output pixel.
REQ-014 m_sof, m_eol, m_eof  out  1 each  first pixel of frame, last pixel of line, last pixel of frame; qualified by m_valid.
REQ-015 busy  out  1  high from the accepted frame_start until the last pixel is transferred.
REQ-016 frame_done  out  1  single-cycle pulse in the cycle after the m_eof transfer.
REQ-017 start_err  out  1  sticky flag set when frame_start arrives while busy is high.

Function
REQ-018 The state machine SHALL have three states: IDLE, FETCH and DRAIN.
- IDLE -> FETCH on frame_start.
- FETCH -> DRAIN after the read of address IMG_W*IMG_H-1 is issued.
- DRAIN -> IDLE on the m_eof transfer.
REQ-019 In FETCH, the block SHALL issue a read only when FIFO occupancy plus in-flight reads is less than FIFO_DEPTH (credit rule), so the FIFO never overflows.
REQ-020 Addresses SHALL be issued in raster order: 0, 1, ..., IMG_W*IMG_H-1, with no skips or repeats.
REQ-021 ROM data SHALL be written into the FIFO in the cycle it is valid; the FIFO head drives m_data and m_valid.
REQ-022 The x and y counters SHALL advance only on an output transfer, and the flags SHALL be generated from them:
- m_sof when x=0 and y=0.
- m_eol when x=IMG_W-1.
- m_eof when x=IMG_W-1 and y=IMG_H-1.
REQ-023 With m_ready held high, the first m_valid SHALL appear 2 cycles after frame_start, and throughput SHALL then be 1 pixel per cycle.
REQ-024 When m_ready is low, m_data and the flags SHALL hold stable while m_valid is high.
REQ-025 A frame_start while busy SHALL be ignored and SHALL set start_err; start_err clears only on rst.
REQ-026 A frame_start in the same cycle as frame_done SHALL be accepted, with no error.
REQ-027 rom_addr SHALL hold its last value when rom_rd_en is low.

Reset
REQ-028 On rst, all of the following SHALL go to 0 on the next clk edge: state (to IDLE), counters, FIFO pointers, in-flight count, rom_addr, rom_rd_en, m_valid, m_data, all flags, busy, frame_done and start_err.
REQ-029 An rst during FETCH or DRAIN SHALL discard buffered and in-flight data; ROM data returning in the cycle after rst SHALL NOT enter the FIFO.

Structure
REQ-030 Package rom_ctrl_pkg SHALL hold the state enumeration and the ROM latency constant (1).
REQ-031 The FIFO SHALL be a sub-module rom_rd_fifo: synchronous, FIFO_DEPTH entries, with full, empty and count outputs.

Verification (IMG_W=4, IMG_H=2, ROM word = address)
REQ-032 Pulse frame_start with m_ready=1 -> m_data sequence 0..7; m_sof on 0; m_eol on 3 and 7; m_eof on 7; frame_done one cycle after 7.
REQ-033 Toggle m_ready 1,0,0,1 repeatedly -> no pixel lost or duplicated; FIFO count never exceeds 4; m_data stable while stalled.
REQ-034 Hold m_ready=0 for 20 cycles after start -> exactly 4 reads issued, then rom_rd_en stays low until m_ready rises.
REQ-035 Pulse frame_start again during pixel 3 -> start_err=1 and the frame completes normally with 8 pixels.
REQ-036 Assert rst while pixel 5 is pending -> all outputs 0 next cycle; a new frame_start yields 0..7 cleanly.
REQ-037 Pulse frame_start coincident with frame_done -> a second frame of 0..7 follows, and start_err stays 0.
